mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single memory port, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN to alternate between ports under contention instead of fixed data priority.
module mem_arbiter #(
   parameter int RSP_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_req_i,
   input  logic [63:0] i_addr_i,
   output logic        i_gnt_o,
   output logic        i_rvalid_o,
   output logic [31:0] i_rdata_o,
   input  logic        d_req_i,
   input  logic [63:0] d_addr_i,
   input  logic        d_wr_i,
   input  logic [1:0]  d_byte_en_i,
   input  logic [63:0] d_wdata_i,
   output logic        d_gnt_o,
   output logic        d_rvalid_o,
   output logic [63:0] d_rdata_o,
   output logic        m_req_o,
   output logic [63:0] m_addr_o,
   output logic        m_wr_o,
   output logic [1:0]  m_byte_en_o,
   output logic [63:0] m_wdata_o,
   input  logic        m_gnt_i,
   input  logic        m_rvalid_i,
   input  logic [63:0] m_rdata_i,
   output logic        err_o
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] RSP  = 2'd2;
   localparam logic [9:0] TMO  = RSP_TIMEOUT[9:0];

   logic [1:0]  state;
   logic        owner_d;
   logic [9:0]  cnt;
   logic [31:0] i_rdata_q;
   logic [63:0] d_rdata_q;
   logic        pick_d;
   logic        gnt;
   logic        rsp_hit;
   logic        tmo;
   logic        done;
   logic [31:0] i_rdata_new;
   logic [63:0] d_rdata_new;

`ifdef ARB_ROUND_ROBIN_EN
   // 1: data port has priority on the next contended arbitration
   logic prio_d;
`endif

   always_comb begin
      pick_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      pick_d = d_req_i && (!i_req_i || prio_d);
`else
      pick_d = d_req_i;
`endif
   end

   assign gnt     = (state == REQ) && m_gnt_i;
   assign rsp_hit = (state == RSP) && m_rvalid_i;
   assign tmo     = (state == RSP) && !m_rvalid_i && (cnt == TMO);
   assign done    = rsp_hit || tmo;

   assign i_gnt_o    = gnt && !owner_d;
   assign d_gnt_o    = gnt && owner_d;
   assign i_rvalid_o = done && !owner_d;
   assign d_rvalid_o = done && owner_d;
   assign err_o      = tmo;
   assign m_req_o    = (state == REQ);

   // Fetch word lane chosen by the registered address; a timeout delivers zero data.
   assign i_rdata_new = tmo ? 32'd0 : (m_addr_o[2] ? m_rdata_i[63:32] : m_rdata_i[31:0]);
   assign d_rdata_new = tmo ? 64'd0 : m_rdata_i;

   // Response data is visible in the rvalid cycle and held from the register afterwards.
   assign i_rdata_o = i_rvalid_o ? i_rdata_new : i_rdata_q;
   assign d_rdata_o = d_rvalid_o ? d_rdata_new : d_rdata_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         owner_d     <= 1'b0;
         cnt         <= 10'd0;
         i_rdata_q   <= 32'd0;
         d_rdata_q   <= 64'd0;
         m_addr_o    <= 64'd0;
         m_wr_o      <= 1'b0;
         m_byte_en_o <= 2'b00;
         m_wdata_o   <= 64'd0;
`ifdef ARB_ROUND_ROBIN_EN
         prio_d      <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (i_req_i || d_req_i) begin
                  owner_d     <= pick_d;
                  m_addr_o    <= pick_d ? d_addr_i : i_addr_i;
                  m_wr_o      <= pick_d && d_wr_i;
                  m_byte_en_o <= pick_d ? d_byte_en_i : 2'b11;
                  m_wdata_o   <= pick_d ? d_wdata_i : 64'd0;
                  state       <= REQ;
               end
            end
            REQ: begin
               if (m_gnt_i) begin
                  cnt   <= 10'd0;
                  state <= RSP;
`ifdef ARB_ROUND_ROBIN_EN
                  prio_d <= !owner_d;
`endif
               end
            end
            RSP: begin
               if (done) begin
                  state <= IDLE;
                  if (owner_d) d_rdata_q <= d_rdata_new;
                  else         i_rdata_q <= i_rdata_new;
               end else begin
                  cnt <= cnt + 10'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;
   localparam int T = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        i_req_i, d_req_i, d_wr_i, m_gnt_i, m_rvalid_i;
   logic [63:0] i_addr_i, d_addr_i, d_wdata_i, m_rdata_i;
   logic [1:0]  d_byte_en_i;
   logic        i_gnt_o, i_rvalid_o, d_gnt_o, d_rvalid_o, m_req_o, m_wr_o, err_o;
   logic [31:0] i_rdata_o;
   logic [63:0] d_rdata_o, m_addr_o, m_wdata_o;
   logic [1:0]  m_byte_en_o;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference state: which port got the most recent grant, and last data seen per port.
   logic        last_i;
   logic [31:0] exp_ir;
   logic [63:0] exp_dr;

   always #5 clk = ~clk;

   mem_arbiter #(.RSP_TIMEOUT(T)) dut (
      .clk(clk), .reset_n(reset_n),
      .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
      .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
      .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_wr_i(d_wr_i),
      .d_byte_en_i(d_byte_en_i), .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o),
      .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
      .m_req_o(m_req_o), .m_addr_o(m_addr_o), .m_wr_o(m_wr_o),
      .m_byte_en_o(m_byte_en_o), .m_wdata_o(m_wdata_o),
      .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
      .err_o(err_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".m_req"}, 64'(m_req_o), 64'd0);
      chk({tag, ".gnt"}, {62'd0, i_gnt_o, d_gnt_o}, 64'd0);
      chk({tag, ".rvalid"}, {62'd0, i_rvalid_o, d_rvalid_o}, 64'd0);
      chk({tag, ".err"}, 64'(err_o), 64'd0);
      chk({tag, ".i_rdata"}, 64'(i_rdata_o), 64'(exp_ir));
      chk({tag, ".d_rdata"}, d_rdata_o, exp_dr);
   endtask

   function automatic logic data_preferred();
`ifdef ARB_ROUND_ROBIN_EN
      return last_i;
`else
      return 1'b1;
`endif
   endfunction

   // One complete transaction: arbitration cycle, gd cycles of backpressure, then a
   // response in RSP cycle rdl (if rdl > T the timeout fires in RSP cycle T instead).
   task automatic txn(input logic ri, input logic rd, input logic [63:0] ia,
                      input logic [63:0] da, input logic dwr, input logic [1:0] dbe,
                      input logic [63:0] dwd, input int gd, input int rdl,
                      input logic [63:0] mrd, input logic keep);
      logic own_d, ewr, fin, to;
      logic [63:0] ea, ew;
      logic [1:0]  ebe;
      @(negedge clk);
      i_req_i = ri; d_req_i = rd; i_addr_i = ia; d_addr_i = da;
      d_wr_i = dwr; d_byte_en_i = dbe; d_wdata_i = dwd; m_rdata_i = mrd;
      m_gnt_i = 1'($urandom); m_rvalid_i = 1'($urandom);
      #1 chk_quiet("arb");
      if (!ri && !rd) return;
      own_d = rd && (!ri || data_preferred());
      ea  = own_d ? da : ia;
      ewr = own_d && dwr;
      ebe = own_d ? dbe : 2'b11;
      ew  = own_d ? dwd : 64'd0;
      for (int k = 0; k <= gd; k++) begin
         @(negedge clk);
         if (!keep) begin i_req_i = 1'b0; d_req_i = 1'b0; end
         i_addr_i = {$urandom, $urandom}; d_addr_i = {$urandom, $urandom};
         d_wdata_i = {$urandom, $urandom}; d_wr_i = 1'($urandom);
         m_gnt_i = (k == gd); m_rvalid_i = 1'($urandom);
         #1;
         chk("req.m_req", 64'(m_req_o), 64'd1);
         chk("req.m_addr", m_addr_o, ea);
         chk("req.m_wr", 64'(m_wr_o), 64'(ewr));
         chk("req.m_be", 64'(m_byte_en_o), 64'(ebe));
         chk("req.m_wdata", m_wdata_o, ew);
         chk("req.i_gnt", 64'(i_gnt_o), 64'((k == gd) && !own_d));
         chk("req.d_gnt", 64'(d_gnt_o), 64'((k == gd) && own_d));
         chk("req.rvalid", {62'd0, i_rvalid_o, d_rvalid_o}, 64'd0);
         chk("req.err", 64'(err_o), 64'd0);
      end
      last_i = !own_d;
      for (int j = 0; j <= T; j++) begin
         @(negedge clk);
         m_gnt_i = 1'($urandom); m_rvalid_i = (j == rdl);
         #1;
         fin = (j == rdl) || (j == T);
         to  = (j != rdl) && (j == T);
         if (fin) begin
            if (own_d) exp_dr = to ? 64'd0 : mrd;
            else       exp_ir = to ? 32'd0 : (ea[2] ? mrd[63:32] : mrd[31:0]);
         end
         chk("rsp.m_req", 64'(m_req_o), 64'd0);
         chk("rsp.gnt", {62'd0, i_gnt_o, d_gnt_o}, 64'd0);
         chk("rsp.i_rvalid", 64'(i_rvalid_o), 64'(fin && !own_d));
         chk("rsp.d_rvalid", 64'(d_rvalid_o), 64'(fin && own_d));
         chk("rsp.err", 64'(err_o), 64'(to));
         chk("rsp.i_rdata", 64'(i_rdata_o), 64'(exp_ir));
         chk("rsp.d_rdata", d_rdata_o, exp_dr);
         if (fin) break;
      end
   endtask

   // Idle cycle with stray memory handshakes that must be ignored.
   task automatic stray(input string tag);
      @(negedge clk);
      i_req_i = 1'b0; d_req_i = 1'b0; m_gnt_i = 1'b1; m_rvalid_i = 1'b1;
      #1 chk_quiet(tag);
   endtask

   initial begin
      reset_n = 1'b0;
      i_req_i = 0; d_req_i = 0; d_wr_i = 0; m_gnt_i = 0; m_rvalid_i = 0;
      i_addr_i = 0; d_addr_i = 0; d_wdata_i = 0; m_rdata_i = 0; d_byte_en_i = 0;
      last_i = 1'b1; exp_ir = 0; exp_dr = 0;
      #1;
      chk_quiet("reset");
      chk("reset.m_addr", m_addr_o, 64'd0);
      chk("reset.m_fields", {m_wdata_o[60:0], m_wr_o, m_byte_en_o}, 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Fetch from 0x1004: upper word of the memory beat.
      txn(1, 0, 64'h1004, 0, 0, 0, 0, 0, 0, 64'hAAAA_BBBB_CCCC_DDDD, 1);
      chk("fetch.word", 64'(exp_ir), 64'hAAAA_BBBB);

      // Contention: both held, data store to 0x80.
      for (int n = 0; n < 4; n++)
         txn(1, 1, 64'h2000 + 64'(n * 4), 64'h80, 1, 2'b01, 64'h1234, 0, 1,
             {$urandom, $urandom}, 1);

      // Backpressure: five cycles without gnt.
      txn(0, 1, 0, 64'h300, 0, 2'b10, 64'h55, 5, 0, 64'h0123_4567_89AB_CDEF, 0);

      // Timeout, then a late response that must be dropped.
      txn(1, 0, 64'h40, 0, 0, 0, 0, 0, 99, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      stray("late");
      txn(0, 1, 0, 64'h48, 0, 2'b11, 0, 1, 99, 64'hFFFF, 0);
      stray("late_d");

      // Reset while waiting for a response.
      @(negedge clk);
      i_req_i = 1; i_addr_i = 64'h500; d_req_i = 0; m_gnt_i = 0; m_rvalid_i = 0;
      @(negedge clk);
      i_req_i = 0; m_gnt_i = 1;
      @(negedge clk);
      m_gnt_i = 0;
      @(negedge clk);
      reset_n = 1'b0;
      exp_ir = 0; exp_dr = 0; last_i = 1'b1;
      #1;
      chk_quiet("midrst");
      chk("midrst.m_addr", m_addr_o, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      stray("postrst");
      txn(1, 0, 64'h600, 0, 0, 0, 0, 0, 2, 64'h1111_2222_3333_4444, 0);
      chk("postrst.word", 64'(exp_ir), 64'h3333_4444);

      // Randomized traffic.
      for (int n = 0; n < 200; n++)
         txn(1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom), 2'($urandom), {$urandom, $urandom},
             $urandom_range(0, 3), $urandom_range(0, 6), {$urandom, $urandom},
             1'($urandom));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
